// File: rtl/breath_pkg.sv
// Shared types and width helpers for the breathing-LED PWM block.
package breath_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    // Number of PWM ticks in one period; also the largest legal duty value.
    function automatic int full_of(input int pwm_w);
        return 1 << pwm_w;
    endfunction

    // Duty needs one extra bit so that FULL itself is representable.
    function automatic int duty_w_of(input int pwm_w);
        return pwm_w + 1;
    endfunction

endpackage

// File: rtl/breath_led_pwm_pwm_core.sv
// PWM carrier: tick-advanced counter, wrap detect and registered duty compare.
module pwm_core #(
    parameter int PWM_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick,
    input  logic           clr,
    input  logic [PWM_W:0] duty,
    output logic           led,
    output logic           wrap
);

    logic [PWM_W-1:0] cnt;

    assign wrap = tick && (cnt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Duty is forced to zero whenever the FSM is idle, so the compare alone keeps led low there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= 1'b0;
        end else begin
            led <= ({1'b0, cnt} < duty);
        end
    end

endmodule

// File: rtl/breath_led_pwm.sv
// Breathing-LED controller: ramps PWM duty up, holds, ramps down, holds, one step per PWM period.
// Handshake: tick_en is a one-cycle enable; an advance is any cycle with tick_en=1 and en=1.
module breath_led_pwm
    import breath_pkg::*;
#(
    parameter int PWM_W        = 8,
    parameter int STEP         = 4,
    parameter int HOLD_PERIODS = 16
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic           tick_en,
    input  logic           en,
    output logic           led,
    output logic [PWM_W:0] duty,
    output logic           period_done,
    output logic [2:0]     state_o
);

    localparam int DW   = duty_w_of(PWM_W);
    localparam int AW   = PWM_W + 2;
    localparam int FULL = full_of(PWM_W);
    localparam int HW   = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

    localparam logic [AW-1:0] FULL_A    = AW'(FULL);
    localparam logic [AW-1:0] STEP_A    = AW'(STEP);
    localparam logic [DW-1:0] FULL_D    = DW'(FULL);
    localparam logic [DW-1:0] STEP_D    = DW'(STEP);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_PERIODS - 1);

    state_t          state_q, state_d;
    logic [DW-1:0]   duty_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            advance;
    logic            wrap;
    logic [AW-1:0]   duty_ext;
    logic [AW-1:0]   up_sum;
    logic [DW-1:0]   duty_up;
    logic [DW-1:0]   duty_dn;

    assign advance = tick_en & en;
    assign state_o = state_q;

    // Saturating step arithmetic; the wider sum cannot overflow before the clamp.
    assign duty_ext = {1'b0, duty};
    assign up_sum   = duty_ext + STEP_A;
    assign duty_up  = (up_sum > FULL_A) ? FULL_D : up_sum[DW-1:0];
    assign duty_dn  = (duty_ext > STEP_A) ? (duty - STEP_D) : '0;

    pwm_core #(
        .PWM_W (PWM_W)
    ) u_pwm_core (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .tick (advance),
        .clr  (~en),
        .duty (duty),
        .led  (led),
        .wrap (wrap)
    );

    always_comb begin
        state_d = state_q;
        duty_d  = duty;
        hold_d  = hold_q;
        if (!en) begin
            state_d = IDLE;
            duty_d  = '0;
            hold_d  = '0;
        end else if (advance) begin
            if (state_q == IDLE) begin
                state_d = RISE;
                duty_d  = '0;
                hold_d  = '0;
            end else if (wrap) begin
                case (state_q)
                    RISE: begin
                        duty_d = duty_up;
                        if (duty_up == FULL_D) begin
                            state_d = HOLD_HI;
                            hold_d  = '0;
                        end
                    end
                    HOLD_HI: begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = FALL;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                    FALL: begin
                        duty_d = duty_dn;
                        if (duty_dn == '0) begin
                            state_d = HOLD_LO;
                            hold_d  = '0;
                        end
                    end
                    HOLD_LO: begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = RISE;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        duty_d  = '0;
                        hold_d  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            duty        <= '0;
            hold_q      <= '0;
            period_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            duty        <= duty_d;
            hold_q      <= hold_d;
            period_done <= wrap;
        end
    end

endmodule
